// File: rtl/key_assembler_pkg.sv
// key_assembler_pkg: shared state encoding and default widths for the key assembler and encrypt stage.
package key_assembler_pkg;
  localparam int DEF_MSG_SIZE = 8;
  localparam int DEF_CHUNK_SIZE = 4;
  localparam int SYNC_STAGES = 2;
  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
endpackage

// File: rtl/key_assembler_sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer followed by a single-cycle rising-edge pulse.
module sync_edge_detect
  import key_assembler_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic edge_pulse
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      prev <= sync[SYNC_STAGES-1];
    end
  assign edge_pulse = sync[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/key_assembler.sv
// key_assembler: builds a key from strobed chunks, flags completion and issues one-cycle encrypt requests.
module key_assembler
  import key_assembler_pkg::*;
#(
  parameter int MSG_SIZE = DEF_MSG_SIZE,
  parameter int CHUNK_SIZE = DEF_CHUNK_SIZE
) (
  input  logic                                        iClk,
  input  logic                                        iRst,
  input  logic                                        iEn,
  input  logic                                        iLoad,
  input  logic [CHUNK_SIZE-1:0]                       iChunk,
  input  logic                                        iStart,
  input  logic                                        iClear,
  output logic [MSG_SIZE-1:0]                         oKey_Assembled,
  output logic                                        oKey_Ready,
  output logic                                        oEncrypt,
  output logic [$clog2(MSG_SIZE/CHUNK_SIZE+1)-1:0]    oChunk_Count
);
  localparam int NUM_CHUNKS = MSG_SIZE / CHUNK_SIZE;
  localparam int CW = $clog2(NUM_CHUNKS + 1);
  state_t state, state_n;
  logic [MSG_SIZE-1:0] key_n;
  logic [CW-1:0] count_n;
  logic enc_n, load_edge, start_edge;
  sync_edge_detect u_load (.clk(iClk), .rst_n(iRst), .d(iLoad), .edge_pulse(load_edge));
  sync_edge_detect u_start (.clk(iClk), .rst_n(iRst), .d(iStart), .edge_pulse(start_edge));
  // A start edge in READY wins over a simultaneous load edge; in IDLE the key is already zero.
  always_comb begin
    state_n = state;
    key_n = oKey_Assembled;
    count_n = oChunk_Count;
    enc_n = 1'b0;
    if (iClear) begin
      state_n = IDLE;
      key_n = '0;
      count_n = '0;
    end else if (iEn) begin
      if (state == READY && start_edge) enc_n = 1'b1;
      else if (load_edge) begin
        key_n = (state == READY ? '0 : oKey_Assembled << CHUNK_SIZE) | MSG_SIZE'(iChunk);
        count_n = state == READY ? CW'(1) : oChunk_Count + CW'(1);
        state_n = count_n == CW'(NUM_CHUNKS) ? READY : LOAD;
      end
    end
  end
  always_ff @(posedge iClk or negedge iRst)
    if (!iRst) begin
      state <= IDLE;
      oKey_Assembled <= '0;
      oChunk_Count <= '0;
      oKey_Ready <= 1'b0;
      oEncrypt <= 1'b0;
    end else begin
      state <= state_n;
      oKey_Assembled <= key_n;
      oChunk_Count <= count_n;
      oKey_Ready <= state_n == READY;
      oEncrypt <= enc_n;
    end
endmodule

// File: tb/tb_key_assembler.sv
// tb_key_assembler: scenario tasks with a key/ciphertext scoreboard for key_assembler.
module tb_key_assembler;
  logic iClk = 1'b0, iRst = 1'b0, iEn = 1'b1, iLoad = 1'b0, iStart = 1'b0, iClear = 1'b0;
  logic [3:0] iChunk = 4'h0;
  logic [7:0] key;
  logic ready, enc;
  logic [1:0] cnt;
  int errors = 0, checks = 0;
  logic [7:0] key_q[$];
  logic [7:0] ct_q[$];
  logic [7:0] msg = 8'h3C;

  key_assembler dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iLoad(iLoad), .iChunk(iChunk), .iStart(iStart),
    .iClear(iClear), .oKey_Assembled(key), .oKey_Ready(ready), .oEncrypt(enc), .oChunk_Count(cnt)
  );

  always #5 iClk = ~iClk;

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic pulse_load(input logic [3:0] c, input int hold);
    iChunk = c;
    iLoad = 1'b1;
    repeat (hold) step();
    iLoad = 1'b0;
    repeat (3) step();
  endtask

  task automatic pulse_start(output int pulses);
    pulses = 0;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    repeat (8) begin
      step();
      if (enc) begin
        pulses++;
        if (ct_q.size() != 0) begin
          checks++;
          if ((key ^ msg) !== ct_q[0]) begin
            errors++;
            $display("FAIL cipher: got %h want %h", key ^ msg, ct_q[0]);
          end
          void'(ct_q.pop_front());
        end
      end
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!ready || key_q.size() == 0) begin
      errors++;
      $display("FAIL %s ready: got ready=%b want 1 with queued key", name, ready);
    end else if (key !== key_q[0]) begin
      errors++;
      $display("FAIL %s key: got %h want %h", name, key, key_q[0]);
    end
    if (key_q.size() != 0) void'(key_q.pop_front());
  endtask

  task automatic do_clear();
    iClear = 1'b1;
    step();
    iClear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({key, ready, enc, cnt} !== 12'h000) begin
      errors++;
      $display("FAIL reset: got key=%h ready=%b enc=%b cnt=%0d want all 0", key, ready, enc, cnt);
    end
    iRst = 1'b1;
    step();
  endtask

  task automatic test_two_chunk();
    key_q.push_back(8'hA5);
    pulse_load(4'hA, 4);
    checks++;
    if (key !== 8'h0A || cnt !== 2'd1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL first_chunk: got key=%h cnt=%0d ready=%b want 0a 1 0", key, cnt, ready);
    end
    iChunk = 4'h5;
    iLoad = 1'b1;
    step();
    step();
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_early: got %b want 0", ready);
    end
    step();
    checks++;
    if (ready !== 1'b1 || cnt !== 2'd2) begin
      errors++;
      $display("FAIL ready_latency: got ready=%b cnt=%0d want 1 2", ready, cnt);
    end
    wait_ready("two_chunk");
    step();
    iLoad = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_encrypt();
    int p;
    ct_q.push_back(8'h99);
    pulse_start(p);
    checks++;
    if (p != 1 || ct_q.size() != 0) begin
      errors++;
      $display("FAIL encrypt_pulse: got %0d pulses, %0d unmatched want 1 0", p, ct_q.size());
    end
  endtask

  task automatic test_hold_load();
    do_clear();
    iChunk = 4'h7;
    iLoad = 1'b1;
    repeat (20) step();
    checks++;
    if (key !== 8'h07 || cnt !== 2'd1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_load: got key=%h cnt=%0d ready=%b want 07 1 0", key, cnt, ready);
    end
    iLoad = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_async_reset();
    do_clear();
    pulse_load(4'hC, 4);
    checks++;
    if (key !== 8'h0C) begin
      errors++;
      $display("FAIL pre_reset: got key=%h want 0c", key);
    end
    #2 iRst = 1'b0;
    #1;
    checks++;
    if (key !== 8'h00 || cnt !== 2'd0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got key=%h cnt=%0d ready=%b want 00 0 0", key, cnt, ready);
    end
    step();
    iRst = 1'b1;
    step();
    key_q.push_back(8'h12);
    pulse_load(4'h1, 4);
    pulse_load(4'h2, 4);
    wait_ready("after_reset");
  endtask

  task automatic test_reload();
    int p;
    do_clear();
    key_q.push_back(8'hA5);
    pulse_load(4'hA, 4);
    pulse_load(4'h5, 4);
    wait_ready("reload_base");
    pulse_load(4'h3, 4);
    checks++;
    if (ready !== 1'b0 || key !== 8'h03 || cnt !== 2'd1) begin
      errors++;
      $display("FAIL reload: got key=%h cnt=%0d ready=%b want 03 1 0", key, cnt, ready);
    end
    pulse_start(p);
    checks++;
    if (p != 0) begin
      errors++;
      $display("FAIL start_in_load: got %0d pulses want 0", p);
    end
  endtask

  task automatic test_enable();
    int p;
    iEn = 1'b0;
    pulse_load(4'h9, 4);
    pulse_start(p);
    checks++;
    if (p != 0 || key !== 8'h03 || cnt !== 2'd1) begin
      errors++;
      $display("FAIL disabled: got pulses=%0d key=%h cnt=%0d want 0 03 1", p, key, cnt);
    end
    iChunk = 4'hE;
    iLoad = 1'b1;
    repeat (4) step();
    iEn = 1'b1;
    repeat (4) step();
    checks++;
    if (key !== 8'h03 || cnt !== 2'd1) begin
      errors++;
      $display("FAIL reenable_held: got key=%h cnt=%0d want 03 1", key, cnt);
    end
    iLoad = 1'b0;
    repeat (3) step();
    key_q.push_back(8'h34);
    pulse_load(4'h4, 4);
    wait_ready("enable_complete");
    do_clear();
    checks++;
    if (key !== 8'h00 || ready !== 1'b0 || cnt !== 2'd0) begin
      errors++;
      $display("FAIL clear: got key=%h cnt=%0d ready=%b want 00 0 0", key, cnt, ready);
    end
    pulse_load(4'h6, 4);
    checks++;
    if (key !== 8'h06 || cnt !== 2'd1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_clear: got key=%h cnt=%0d ready=%b want 06 1 0", key, cnt, ready);
    end
  endtask

  task automatic test_back_to_back();
    int p = 0;
    key_q.push_back(8'h6B);
    pulse_load(4'hB, 4);
    wait_ready("b2b");
    msg = 8'hF0;
    ct_q.push_back(8'h9B);
    iChunk = 4'hF;
    iLoad = 1'b1;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    repeat (8) begin
      step();
      if (enc) begin
        p++;
        checks++;
        if ((key ^ msg) !== ct_q[0]) begin
          errors++;
          $display("FAIL b2b_cipher: got %h want %h", key ^ msg, ct_q[0]);
        end
        void'(ct_q.pop_front());
      end
    end
    iLoad = 1'b0;
    repeat (3) step();
    checks++;
    if (p != 1 || key !== 8'h6B || ready !== 1'b1 || cnt !== 2'd2) begin
      errors++;
      $display("FAIL start_wins: got pulses=%0d key=%h ready=%b cnt=%0d want 1 6b 1 2", p, key, ready, cnt);
    end
  endtask

  initial begin
    test_reset();
    test_two_chunk();
    test_encrypt();
    test_hold_load();
    test_async_reset();
    test_reload();
    test_enable();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
